// File: rtl/cnn16_mem_pkg.sv
// Shared definitions for the CNN16 memory responder: bus widths, FSM encoding and
// the helper that sizes the wait-state counter.
package cnn16_mem_pkg;

    localparam int CNN16_ADDR_W = 12;
    localparam int CNN16_DATA_W = 16;

    typedef logic [1:0] mem_state_t;

    localparam mem_state_t ST_IDLE = 2'd0;
    localparam mem_state_t ST_WAIT = 2'd1;
    localparam mem_state_t ST_RESP = 2'd2;

    // Counter must hold max(READ_LAT, WRITE_LAT) - 1; sized on max+1 so it is never zero-width.
    function automatic int lat_cnt_w(input int rd_lat, input int wr_lat);
        int max_lat;
        max_lat = (rd_lat > wr_lat) ? rd_lat : wr_lat;
        return $clog2(max_lat + 1);
    endfunction

endpackage

// File: rtl/cnn16_sp_ram.sv
// Single-port word array: synchronous write, combinational read, no reset.
module cnn16_sp_ram #(
    parameter int DEPTH  = 4096,
    parameter int DATA_W = 16,
    parameter int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_r [DEPTH];

    // Write port
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[addr] <= wdata;
        end
    end

    assign rdata = mem_r[addr];

endmodule

// File: rtl/cnn16_mem_responder.sv
// Memory-side responder for the CNN16 processor port: latches a request, counts
// per-direction wait states, then completes it with a one-cycle mem_ready pulse.
module cnn16_mem_responder
    import cnn16_mem_pkg::*;
#(
    parameter int ADDR_W    = CNN16_ADDR_W,
    parameter int DATA_W    = CNN16_DATA_W,
    parameter int DEPTH     = 4096,
    parameter int READ_LAT  = 2,
    parameter int WRITE_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mem_req,
    input  logic              write_en,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] to_memory,
    output logic [DATA_W-1:0] from_memory,
    output logic              mem_ready,
    output logic              mem_err,
    input  logic              init_we,
    input  logic [ADDR_W-1:0] init_addr,
    input  logic [DATA_W-1:0] init_data
);

    localparam int CNT_W  = lat_cnt_w(READ_LAT, WRITE_LAT);
    localparam int RAM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(READ_LAT - 1);
    localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WRITE_LAT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    mem_state_t        state_r;
    mem_state_t        next_state_s;

    logic [ADDR_W-1:0] req_addr_r;
    logic              req_we_r;
    logic [DATA_W-1:0] req_data_r;
    logic [CNT_W-1:0]  cnt_r;

    logic              accept_s;
    logic              eff_we_s;
    logic [ADDR_W-1:0] ram_addr_s;
    logic              ram_in_range_s;
    logic              ram_we_s;
    logic [DATA_W-1:0] ram_wdata_s;
    logic [DATA_W-1:0] ram_rdata_s;

    logic              ready_s;
    logic              err_s;
    logic              rd_upd_s;
    logic [DATA_W-1:0] rd_val_s;

    logic [DATA_W-1:0] from_memory_r;
    logic              mem_ready_r;
    logic              mem_err_r;

    // A preload strobe in IDLE wins the port, so the CPU request is retried next cycle.
    assign accept_s = (state_r == ST_IDLE) && mem_req && !init_we;
    assign eff_we_s = (state_r == ST_IDLE) ? write_en : req_we_r;

    // Single RAM port shared by preload, the live request (LAT==1 read from IDLE) and the latched access
    always_comb begin
        ram_addr_s  = req_addr_r;
        ram_wdata_s = req_data_r;
        ram_we_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (init_we) begin
                    ram_addr_s  = init_addr;
                    ram_wdata_s = init_data;
                    ram_we_s    = 1'b1;
                end else begin
                    ram_addr_s  = address;
                    ram_wdata_s = to_memory;
                    ram_we_s    = 1'b0;
                end
            end
            ST_RESP: begin
                ram_we_s = req_we_r;
            end
            default: begin
                ram_we_s = 1'b0;
            end
        endcase
    end

    assign ram_in_range_s = (32'(ram_addr_s) < 32'(DEPTH));

    cnn16_sp_ram #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .AW     (RAM_AW)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we_s && ram_in_range_s),
        .addr  (ram_addr_s[RAM_AW-1:0]),
        .wdata (ram_wdata_s),
        .rdata (ram_rdata_s)
    );

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic
    always_comb begin
        next_state_s = ST_IDLE;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    if ((write_en ? WR_LOAD : RD_LOAD) == '0) begin
                        next_state_s = ST_RESP;
                    end else begin
                        next_state_s = ST_WAIT;
                    end
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_r <= CNT_ONE) begin
                    next_state_s = ST_RESP;
                end else begin
                    next_state_s = ST_WAIT;
                end
            end
            ST_RESP: begin
                next_state_s = ST_IDLE;
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // Output decode for the cycle being entered; the RAM port is on the access address here
    always_comb begin
        ready_s  = (next_state_s == ST_RESP);
        err_s    = 1'b0;
        rd_upd_s = 1'b0;
        rd_val_s = '0;
        if (ready_s) begin
            err_s    = !ram_in_range_s;
            rd_upd_s = !eff_we_s;
            rd_val_s = ram_in_range_s ? ram_rdata_s : '0;
        end else begin
            err_s    = 1'b0;
            rd_upd_s = 1'b0;
        end
    end

    // Request latch and wait-state counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            req_addr_r <= '0;
            req_we_r   <= 1'b0;
            req_data_r <= '0;
            cnt_r      <= '0;
        end else if (accept_s) begin
            req_addr_r <= address;
            req_we_r   <= write_en;
            req_data_r <= to_memory;
            cnt_r      <= write_en ? WR_LOAD : RD_LOAD;
        end else if ((state_r == ST_WAIT) && (cnt_r != '0)) begin
            cnt_r <= cnt_r - CNT_ONE;
        end
    end

    // Output registers; read data holds across writes
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_ready_r   <= 1'b0;
            mem_err_r     <= 1'b0;
            from_memory_r <= '0;
        end else begin
            mem_ready_r <= ready_s;
            mem_err_r   <= err_s;
            if (rd_upd_s) begin
                from_memory_r <= rd_val_s;
            end
        end
    end

    assign mem_ready   = mem_ready_r;
    assign mem_err     = mem_err_r;
    assign from_memory = from_memory_r;

endmodule

// File: tb/tb_cnn16_mem_responder.sv
// Directed bench: table-driven accesses on a DEPTH=1024 instance plus hand sequences
// for back-to-back, preload collision and reset-abort on a WRITE_LAT=3 instance.
module tb_cnn16_mem_responder;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst1, req1, we1, iwe1, rdy1, err1;
    logic [11:0] addr1, iaddr1;
    logic [15:0] wd1, idata1, rd1;
    logic        rst2, req2, we2, iwe2, rdy2, err2;
    logic [11:0] addr2, iaddr2;
    logic [15:0] wd2, idata2, rd2;

    int n_tests = 0;
    int n_fail  = 0;

    cnn16_mem_responder #(.DEPTH(1024), .READ_LAT(2), .WRITE_LAT(1)) u_dut (
        .clk(clk), .reset(rst1), .mem_req(req1), .write_en(we1), .address(addr1),
        .to_memory(wd1), .from_memory(rd1), .mem_ready(rdy1), .mem_err(err1),
        .init_we(iwe1), .init_addr(iaddr1), .init_data(idata1)
    );

    cnn16_mem_responder #(.DEPTH(4096), .READ_LAT(2), .WRITE_LAT(3)) u_dut_w3 (
        .clk(clk), .reset(rst2), .mem_req(req2), .write_en(we2), .address(addr2),
        .to_memory(wd2), .from_memory(rd2), .mem_ready(rdy2), .mem_err(err2),
        .init_we(iwe2), .init_addr(iaddr2), .init_data(idata2)
    );

    typedef struct {
        logic        we;
        logic [11:0] addr;
        logic [15:0] data;
        int          lat;
        logic [15:0] exp_data;
        logic        exp_err;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic preload(input bit sel, input logic [11:0] a, input logic [15:0] d);
        @(negedge clk);
        if (sel) begin iwe2 = 1'b1; iaddr2 = a; idata2 = d; end
        else     begin iwe1 = 1'b1; iaddr1 = a; idata1 = d; end
        @(negedge clk);
        iwe1 = 1'b0;
        iwe2 = 1'b0;
    endtask

    // One access; lat is the negedge count after the accepting edge at which mem_ready is seen (0 = never)
    task automatic access(input bit sel, input logic w, input logic [11:0] a, input logic [15:0] d,
                          output int lat, output logic [15:0] rd, output logic er);
        lat = 0;
        rd  = 16'h0000;
        er  = 1'b0;
        @(negedge clk);
        if (sel) begin req2 = 1'b1; we2 = w; addr2 = a; wd2 = d; end
        else     begin req1 = 1'b1; we1 = w; addr1 = a; wd1 = d; end
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (sel ? rdy2 : rdy1) begin
                lat = k;
                rd  = sel ? rd2 : rd1;
                er  = sel ? err2 : err1;
                break;
            end
        end
        req1 = 1'b0;
        req2 = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat;
        logic [15:0] rd;
        logic        er;
        logic [11:0] next_addr [3];
        logic [15:0] exp_rd    [3];
        int          idx;

        vecs[0] = '{1'b0, 12'h010, 16'h0000, 2, 16'hBEEF, 1'b0};
        vecs[1] = '{1'b1, 12'h020, 16'h1234, 1, 16'hBEEF, 1'b0};
        vecs[2] = '{1'b0, 12'h020, 16'h0000, 2, 16'h1234, 1'b0};
        vecs[3] = '{1'b0, 12'h400, 16'h0000, 2, 16'h0000, 1'b1};
        vecs[4] = '{1'b1, 12'h7FF, 16'hDEAD, 1, 16'h0000, 1'b1};
        vecs[5] = '{1'b0, 12'h3FF, 16'h0000, 2, 16'h5A5A, 1'b0};
        vecs[6] = '{1'b1, 12'h3FF, 16'h0001, 1, 16'h5A5A, 1'b0};
        vecs[7] = '{1'b0, 12'h3FF, 16'h0000, 2, 16'h0001, 1'b0};

        rst1 = 1'b1; req1 = 1'b0; we1 = 1'b0; addr1 = 12'h000; wd1 = 16'h0000;
        iwe1 = 1'b0; iaddr1 = 12'h000; idata1 = 16'h0000;
        rst2 = 1'b1; req2 = 1'b0; we2 = 1'b0; addr2 = 12'h000; wd2 = 16'h0000;
        iwe2 = 1'b0; iaddr2 = 12'h000; idata2 = 16'h0000;

        repeat (3) @(negedge clk);
        chk("reset_ready", {31'd0, rdy1}, 32'd0);
        chk("reset_err",   {31'd0, err1}, 32'd0);
        chk("reset_data",  {16'd0, rd1},  32'd0);
        rst1 = 1'b0;
        rst2 = 1'b0;

        preload(1'b0, 12'h010, 16'hBEEF);
        preload(1'b0, 12'h001, 16'h1111);
        preload(1'b0, 12'h002, 16'h2222);
        preload(1'b0, 12'h003, 16'h3333);
        preload(1'b0, 12'h3FF, 16'h5A5A);

        for (int i = 0; i < 8; i++) begin
            access(1'b0, vecs[i].we, vecs[i].addr, vecs[i].data, lat, rd, er);
            chk($sformatf("vec%0d_lat", i),  32'(lat), 32'(vecs[i].lat));
            chk($sformatf("vec%0d_data", i), {16'd0, rd}, {16'd0, vecs[i].exp_data});
            chk($sformatf("vec%0d_err", i),  {31'd0, er}, {31'd0, vecs[i].exp_err});
        end

        // Three reads with mem_req held high; address is wiggled while each access is pending
        next_addr[0] = 12'h002; next_addr[1] = 12'h003; next_addr[2] = 12'h003;
        exp_rd[0] = 16'h1111; exp_rd[1] = 16'h2222; exp_rd[2] = 16'h3333;
        idx = 0;
        @(negedge clk);
        req1 = 1'b1; we1 = 1'b0; addr1 = 12'h001;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            chk($sformatf("b2b_ready_k%0d", k), {31'd0, rdy1}, {31'd0, (k % 3) == 2});
            if ((k % 3) == 2) begin
                chk($sformatf("b2b_data%0d", idx), {16'd0, rd1}, {16'd0, exp_rd[idx]});
                addr1 = next_addr[idx];
                idx++;
                if (k == 8) req1 = 1'b0;
            end else if ((k % 3) == 1) begin
                addr1 = 12'h010;
                we1   = 1'b1;
            end else begin
                we1 = 1'b0;
            end
        end
        req1 = 1'b0;
        we1  = 1'b0;

        // Preload and request collide in IDLE: preload lands, request completes one cycle later
        @(negedge clk);
        iwe1 = 1'b1; iaddr1 = 12'h040; idata1 = 16'h7777;
        req1 = 1'b1; we1 = 1'b0; addr1 = 12'h040;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            iwe1 = 1'b0;
            chk($sformatf("collide_ready_k%0d", k), {31'd0, rdy1}, {31'd0, k == 3});
            if (k == 3) begin
                chk("collide_data", {16'd0, rd1}, 32'h0000_7777);
                req1 = 1'b0;
            end
        end

        // Reset during the WAIT of a WRITE_LAT=3 write aborts it without committing
        preload(1'b1, 12'h030, 16'h4321);
        access(1'b1, 1'b0, 12'h030, 16'h0000, lat, rd, er);
        chk("w3_pre_lat",  32'(lat), 32'd2);
        chk("w3_pre_data", {16'd0, rd}, 32'h0000_4321);
        @(negedge clk);
        req2 = 1'b1; we2 = 1'b1; addr2 = 12'h030; wd2 = 16'hAAAA;
        @(negedge clk);
        chk("abort_wait_ready", {31'd0, rdy2}, 32'd0);
        rst2 = 1'b1;
        #1;
        chk("abort_ready", {31'd0, rdy2}, 32'd0);
        chk("abort_err",   {31'd0, err2}, 32'd0);
        chk("abort_data",  {16'd0, rd2},  32'd0);
        req2 = 1'b0; we2 = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("abort_quiet%0d", k), {31'd0, rdy2}, 32'd0);
        end
        rst2 = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("post_rst_quiet%0d", k), {31'd0, rdy2}, 32'd0);
        end
        access(1'b1, 1'b0, 12'h030, 16'h0000, lat, rd, er);
        chk("w3_post_lat",  32'(lat), 32'd2);
        chk("w3_post_data", {16'd0, rd}, 32'h0000_4321);
        chk("w3_post_err",  {31'd0, er}, 32'd0);

        // Normal WRITE_LAT=3 write and readback
        access(1'b1, 1'b1, 12'h031, 16'h0F0F, lat, rd, er);
        chk("w3_write_lat",  32'(lat), 32'd3);
        chk("w3_write_hold", {16'd0, rd}, 32'h0000_4321);
        access(1'b1, 1'b0, 12'h031, 16'h0000, lat, rd, er);
        chk("w3_readback", {16'd0, rd}, 32'h0000_0F0F);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
